// File: rtl/sb_mixer_lo_ctrl.sv
// sb_mixer_lo_ctrl: LO sequencer for the double-balanced mixer.
// Divides clk into a 50%-duty LO square wave and owns the IF mute. New
// dividers arrive over valid/ready and are applied only on whole-period
// boundaries (lo_out falling edge), so no runt pulses reach the mixer.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         run request (level)
//   cfg_valid  divider offer valid
//   cfg_div    requested half-period in clk cycles (0 treated as 1)
//   cfg_ready  block can accept a divider
//   lo_out     LO drive to the mixer
//   if_mute    IF path mute (high unless in RUN)
//   busy       state != IDLE
//   state      IDLE=0, WARMUP=1, RUN=2, DRAIN=3
module sb_mixer_lo_ctrl #(
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned WARMUP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             lo_out,
  output logic             if_mute,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int unsigned WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               lo_q, lo_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [DIV_W-1:0]   div_act_q, div_act_d;
  logic [DIV_W-1:0]   pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic               ready_q, ready_d;
  logic               mute_q, mute_d;
  logic               busy_q, busy_d;

  logic [DIV_W-1:0]   cfg_div_fix;
  logic               wrap;
  logic               boundary;
  logic               apply;

  // Zero divider would never wrap; treat it as the fastest legal rate.
  assign cfg_div_fix = (cfg_div == '0) ? DIV_ONE : cfg_div;
  assign wrap        = (cnt_q == (div_act_q - DIV_ONE));
  // Period boundary: last cycle of the high half, i.e. lo_out is about to fall.
  assign boundary    = wrap & lo_q;
  assign apply       = boundary & pend_full_q;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lo_q        <= 1'b0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      div_act_q   <= DIV_ONE;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      mute_q      <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      div_act_q   <= div_act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
      mute_q      <= mute_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, divider and handshake logic.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    div_act_d   = div_act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    if (state_q == ST_IDLE) begin
      lo_d  = 1'b0;
      cnt_d = '0;
      // LO is stopped, so a pending divider can be taken immediately.
      if (pend_full_q) begin
        div_act_d   = pend_q;
        pend_full_d = 1'b0;
      end
      if (en) begin
        state_d = ST_WARMUP;
        wcnt_d  = '0;
      end
    end else begin
      if (wrap) begin
        cnt_d = '0;
        lo_d  = ~lo_q;
      end else begin
        cnt_d = cnt_q + DIV_ONE;
      end
      if (apply) begin
        div_act_d   = pend_q;
        pend_full_d = 1'b0;
      end

      case (state_q)
        ST_WARMUP: begin
          wcnt_d = wcnt_q + WCNT_ONE;
          if (!en) begin
            state_d = ST_DRAIN;
          end else if (apply) begin
            // Retune during warm-up restarts the settle window.
            wcnt_d = '0;
          end else if (wcnt_q == WCNT_LAST) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_d = ST_DRAIN;
          end else if (apply) begin
            state_d = ST_WARMUP;
            wcnt_d  = '0;
          end
        end
        ST_DRAIN: begin
          if (boundary) begin
            lo_d    = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Capture only when ready, which implies pending is empty (no apply clash).
    if (cfg_valid && ready_q) begin
      pend_d      = cfg_div_fix;
      pend_full_d = 1'b1;
    end

    ready_d = ~pend_full_d;
    mute_d  = (state_d != ST_RUN);
    busy_d  = (state_d != ST_IDLE);
  end

  assign state     = state_q;
  assign lo_out    = lo_q;
  assign cfg_ready = ready_q;
  assign if_mute   = mute_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sb_mixer_lo_ctrl.sv
// Testbench for sb_mixer_lo_ctrl: directed sequences with a scoreboard of
// expected LO phases (level, length) popped as the DUT completes each phase.
module tb_sb_mixer_lo_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       lo_out;
  logic       if_mute;
  logic       busy;
  logic [1:0] state;

  sb_mixer_lo_ctrl #(.DIV_W(8), .WARMUP_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .lo_out    (lo_out),
    .if_mute   (if_mute),
    .busy      (busy),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ecount = 0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit lvl;
    int len;
  } ph_t;

  ph_t exp_q[$];
  bit  mon_en  = 1'b1;
  bit  run_lvl = 1'b0;
  int  run_len = 0;

  task automatic push_pairs(input int len, input int pairs);
    ph_t p;
    for (int i = 0; i < pairs; i++) begin
      p.lvl = 1'b0; p.len = len; exp_q.push_back(p);
      p.lvl = 1'b1; p.len = len; exp_q.push_back(p);
    end
  endtask

  task automatic ph_done(input bit lvl, input int len);
    ph_t e;
    if (exp_q.size() == 0) begin
      chk("sb_extra_phase", len, 0);
    end else begin
      e = exp_q.pop_front();
      chk("ph_lvl", int'(lvl), int'(e.lvl));
      chk("ph_len", len, e.len);
    end
  endtask

  // Measure LO phase lengths while the block is busy.
  always @(negedge clk) begin
    if (!mon_en || busy !== 1'b1) begin
      if (mon_en && run_len > 0) ph_done(run_lvl, run_len);
      run_len = 0;
    end else if (run_len == 0) begin
      run_lvl = lo_out;
      run_len = 1;
    end else if (lo_out == run_lvl) begin
      run_len++;
    end else begin
      ph_done(run_lvl, run_len);
      run_lvl = lo_out;
      run_len = 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_st(input string tag, input int st, input int lo, input int mute);
    chk({tag, "_state"}, int'(state), st);
    chk({tag, "_lo"}, int'(lo_out), lo);
    chk({tag, "_mute"}, int'(if_mute), mute);
  endtask

  task automatic sb_done(input string tag);
    tick(2);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // One-cycle offer in IDLE; ends on the negedge after the apply edge.
  task automatic load_idle(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    tick(1);
    cfg_valid = 1'b0;
    chk("load_rdy_lo", int'(cfg_ready), 0);
    tick(1);
    chk("load_rdy_hi", int'(cfg_ready), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;

    // Reset values
    tick(1);
    chk_st("rst", 0, 0, 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rdy", int'(cfg_ready), 1);
    tick(1);
    rst = 1'b0;

    // Default divider, warm-up timing
    while (ecount < 10) tick(1);
    push_pairs(1, 9);
    en = 1'b1;
    chk("t1_pre_state", int'(state), 0);
    tick(1);
    chk_st("t1_warm", 1, 0, 1);
    chk("t1_busy", int'(busy), 1);
    tick(15);
    chk_st("t1_warm_end", 1, 1, 1);
    tick(1);
    chk_st("t1_run", 2, 0, 0);
    en = 1'b0;
    tick(1);
    chk_st("t1_drain", 3, 1, 1);
    tick(1);
    chk_st("t1_idle", 0, 0, 1);
    chk("t1_idle_busy", int'(busy), 0);
    sb_done("t1");

    // Divider load in IDLE, then retune in RUN
    load_idle(8'd3);
    push_pairs(3, 3);
    push_pairs(5, 2);
    en = 1'b1;
    tick(1);
    chk_st("t2_warm", 1, 0, 1);
    tick(15);
    chk_st("t2_warm_end", 1, 1, 1);
    tick(1);
    chk_st("t2_run", 2, 1, 0);
    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    tick(1);
    cfg_valid = 1'b0;
    chk("t3_rdy_lo", int'(cfg_ready), 0);
    chk_st("t3_hold", 2, 1, 0);
    tick(1);
    chk("t3_rdy_hi", int'(cfg_ready), 1);
    chk_st("t3_rewarm", 1, 0, 1);
    tick(15);
    chk_st("t3_rewarm_end", 1, 1, 1);
    tick(1);
    chk_st("t3_run", 2, 1, 0);
    en = 1'b0;
    tick(1);
    chk_st("t3_drain", 3, 1, 1);
    tick(3);
    chk_st("t3_idle", 0, 0, 1);
    sb_done("t3");

    // Clean stop at div=4
    load_idle(8'd4);
    push_pairs(4, 3);
    en = 1'b1;
    tick(17);
    chk_st("t4_run", 2, 0, 0);
    tick(1);
    en = 1'b0;
    chk_st("t4_low2", 2, 0, 0);
    tick(1);
    chk_st("t4_drain", 3, 0, 1);
    tick(5);
    chk_st("t4_drain_hi", 3, 1, 1);
    tick(1);
    chk_st("t4_idle", 0, 0, 1);
    sb_done("t4");

    // Zero divider behaves as div=1
    load_idle(8'd0);
    push_pairs(1, 9);
    en = 1'b1;
    tick(1);
    chk_st("t5_warm", 1, 0, 1);
    tick(16);
    chk_st("t5_run", 2, 0, 0);
    en = 1'b0;
    tick(1);
    chk_st("t5_drain", 3, 1, 1);
    tick(1);
    chk_st("t5_idle", 0, 0, 1);
    sb_done("t5");

    // Reset mid-RUN at div=7 with a pending value held
    mon_en = 1'b0;
    load_idle(8'd7);
    en = 1'b1;
    tick(17);
    chk_st("t6_run", 2, 0, 0);
    cfg_valid = 1'b1;
    cfg_div   = 8'd2;
    tick(1);
    cfg_valid = 1'b0;
    chk("t6_pend_rdy", int'(cfg_ready), 0);
    tick(1);
    rst = 1'b1;
    en  = 1'b0;
    tick(1);
    chk_st("t6_rst", 0, 0, 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_rdy", int'(cfg_ready), 1);
    rst = 1'b0;
    mon_en = 1'b1;
    push_pairs(1, 9);
    en = 1'b1;
    tick(1);
    chk_st("t6_warm", 1, 0, 1);
    tick(16);
    chk_st("t6_run2", 2, 0, 0);
    en = 1'b0;
    tick(1);
    chk_st("t6_drain", 3, 1, 1);
    tick(1);
    chk_st("t6_idle", 0, 0, 1);
    sb_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sb_mixer_lo_ctrl.md
# sb_mixer_lo_ctrl

Digital LO sequencer for the double-balanced mixer. It divides the system clock into a 50%-duty LO square wave that drives the mixer's LO input. It also owns the IF mute signal, which keeps the IF path quiet while the LO starts, retunes or stops. Divider updates arrive over a valid/ready handshake and take effect only on whole-period boundaries, so the mixer never sees a runt LO pulse.

## Interface

**Parameters**
- DIV_W, 8: width of the half-period divider value.
- WARMUP_CYCLES, 16: clk cycles the IF stays muted after the LO starts or retunes (≥1).

**Ports**
- clk  in  1: system clock, single domain.
- rst  in  1: reset; synchronous, active-high.
- en  in  1: run request; level-sensitive.
- cfg_valid  in  1: new divider offered.
- cfg_div  in  DIV_W: requested LO half-period in clk cycles; 0 is coerced to 1.
- cfg_ready  out  1: block can accept a divider value.
- lo_out  out  1: LO drive to the mixer LOIN input.
- if_mute  out  1: high means the IF path must be muted.
- busy  out  1: high when state ≠ IDLE.
- state  out  2: IDLE=0, WARMUP=1, RUN=2, DRAIN=3.

## Operation

**Reset**
- state=IDLE, lo_out=0, if_mute=1, busy=0, cfg_ready=1.
- div_act=1, pending empty, cnt=0, wcnt=0.

**Configuration**
- Capture: when cfg_valid & cfg_ready, cfg_div (0 coerced to 1) goes into pending.
- cfg_ready is registered and equals the inverse of pending-full.
- cfg_valid while cfg_ready=0 is ignored. The requester must hold its value.
- In IDLE, pending moves into div_act on the next edge.
- In WARMUP, RUN or DRAIN, pending moves into div_act only at a period boundary.

**Divider**
- Active in WARMUP, RUN and DRAIN.
- Each cycle: if cnt==div_act-1, then cnt←0 and lo_out←~lo_out; otherwise cnt←cnt+1.
- On entry to WARMUP: cnt=0, lo_out=0.
- Resulting waveform: lo_out low for div_act cycles, then high for div_act cycles. Period = 2·div_act.
- Period boundary = the cycle with cnt==div_act-1 and lo_out==1, i.e. the edge where lo_out falls.

**State machine**
- IDLE
  - lo_out=0, cnt held at 0.
  - en=1 → WARMUP, with wcnt←0.
  - If a pending apply and the WARMUP transition happen on the same edge, the new div_act is in force from the first WARMUP cycle.
- WARMUP
  - Divider runs; wcnt increments each cycle.
  - wcnt==WARMUP_CYCLES-1 → RUN.
  - en=0 → DRAIN; this takes priority over the transition to RUN.
- RUN
  - en=0 → DRAIN.
  - Pending applied at a boundary → WARMUP with wcnt←0 (IF re-muted while the new LO settles).
- DRAIN
  - Divider continues until the next boundary.
  - At the boundary: apply pending if present, lo_out←0, cnt←0, go to IDLE.
  - en re-asserted during DRAIN does not abort it; en is resampled in IDLE.

**Outputs**
- if_mute = (state≠RUN).
- busy = (state≠IDLE).
- All outputs are registered.

## Timing

- en sampled high at edge k → state=WARMUP at k+1. The first lo_out rise is at k+1+div_act.
- RUN (if_mute=0) is reached at k+1+WARMUP_CYCLES.
- en sampled low at edge j while in RUN → if_mute=1 and state=DRAIN at j+1. lo_out finishes its current period, then IDLE.
- Handshake: capture at edge c → cfg_ready=0 at c+1.
  - In IDLE: applied at edge c+1, cfg_ready=1 at c+2.
  - Otherwise: cfg_ready returns to 1 the cycle after the applying boundary.
- Every lo_out high and low phase lasts exactly the div_act in force at the start of that period. No runt pulses.
- rst has priority over all events: all outputs take reset values on the next edge, including mid-RUN and mid-DRAIN.

## Test plan

1. **Default divider, warm-up timing**
   - Stimulus: rst, then en=1 at edge 10, default div=1.
   - Response: lo_out toggles every cycle from edge 12; if_mute falls at edge 27; state goes 0→1→2.
2. **Divider load in IDLE**
   - Stimulus: in IDLE, cfg_div=3 with cfg_valid for one cycle, then en=1.
   - Response: cfg_ready is low for exactly 1 cycle; lo_out is 3 cycles low, 3 high, repeating.
3. **Retune in RUN**
   - Stimulus: in RUN at div=3, offer cfg_div=5 during a high half.
   - Response: cfg_ready=0 until the next lo_out fall; the current period completes at 3/3; then 5/5; if_mute=1 for 16 cycles after the boundary, then 0.
4. **Clean stop**
   - Stimulus: in RUN at div=4, en=0 on the 2nd cycle of a low half.
   - Response: if_mute=1 next cycle; lo_out completes 2 more low and 4 high cycles; IDLE with lo_out=0; no phase shorter than 4.
5. **Zero divider coercion**
   - Stimulus: cfg_div=0.
   - Response: behaviour identical to div=1, period 2.
6. **Reset mid-operation**
   - Stimulus: rst pulsed in RUN at div=7, with a pending value held.
   - Response: next edge gives state=IDLE, lo_out=0, if_mute=1, cfg_ready=1, div_act=1.
